serial_subtractor_4bit: RTL and testbench



---
 rtl/serial_subtractor_4bit.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor_4bit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_4bit.sv
// rtl/serial_subtractor_4bit.sv - bit-serial a - b - bin, one bit per clock, start/busy/done handshake.
// Optional macro SUB_OVERFLOW_EN adds a registered two's-complement overflow output (ovf).
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit;
  logic             brw_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] res_sh;

`ifdef SUB_OVERFLOW_EN
  // Operand sign bits are shifted out of a_q/b_q, so keep copies for the overflow term.
  logic amsb_q, amsb_d;
  logic bmsb_q, bmsb_d;
  logic ovf_q, ovf_d;
`endif

  assign d_bit    = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign res_sh   = WIDTH'({d_bit, res_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SUB_OVERFLOW_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_sh;
        brw_d = brw_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          diff_d  = res_sh;
          bout_d  = brw_nxt;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = (amsb_q ^ bmsb_q) & (d_bit ^ amsb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SUB_OVERFLOW_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SUB_OVERFLOW_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// tb/tb_serial_subtractor_4bit.sv - scoreboard bench for serial_subtractor_4bit, directed vectors.
module tb_serial_subtractor_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       bin = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;
`ifdef SUB_OVERFLOW_EN
  logic       ovf;
`endif

  serial_subtractor_4bit #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Expected results, {ovf, bout, diff}
  logic [5:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [3:0] last_diff = 4'd0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("queue_has_entry_at_done", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("diff", int'(diff), int'(e[3:0]));
          check("bout", int'(bout), int'(e[4]));
`ifdef SUB_OVERFLOW_EN
          check("ovf", int'(ovf), int'(e[5]));
`endif
        end
      end
    end
  end

  // One operation; if poke is set, start is re-asserted with other operands during SHIFT.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                        input logic [3:0] ed, input logic eb, input logic eo, input bit poke);
    int n;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    exp_q.push_back({eo, eb, ed});
    n = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (poke && (n == 2)) begin a = 4'hF; b = 4'h0; start = 1'b1; end
      if (n == 4) start = 1'b0;
      if (n == 2) check("diff_holds_during_shift", int'(diff), int'(last_diff));
      if (busy === 1'b1) busy_cnt++;
    end while (done !== 1'b1 && n < 20);
    check("done_latency", n, 5);
    check("busy_cycles", busy_cnt, 4);
    check("busy_low_in_done", int'(busy), 0);
    last_diff = ed;
  endtask

  initial begin
    int n;
    int d_cnt;
    int t_done[3];

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_op(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 4'b1000; b = 4'b0001; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 1'b0, 4'b0111});
    n = 0;
    d_cnt = 0;
    while (d_cnt < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        t_done[d_cnt] = n;
        d_cnt++;
        if (d_cnt == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_done_count", d_cnt, 3);
    if (d_cnt == 3) begin
      check("b2b_first_done", t_done[0], 5);
      check("b2b_interval_1", t_done[1] - t_done[0], 5);
      check("b2b_interval_2", t_done[2] - t_done[1], 5);
    end
    last_diff = 4'b0111;

    // Reset two cycles into an operation.
    @(negedge clk);
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_bout", int'(bout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) d_cnt++;
    end
    check("no_done_after_abort", d_cnt, 0);
    last_diff = 4'd0;

    run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
